// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and a
// constant clog2 helper used to size the RAS count and pointer.
package pc_pkg;

  typedef logic [2:0] pc_sel_t;

  localparam pc_sel_t SEL_SEQ  = 3'd0;
  localparam pc_sel_t SEL_BR   = 3'd1;
  localparam pc_sel_t SEL_JMP  = 3'd2;
  localparam pc_sel_t SEL_CALL = 3'd3;
  localparam pc_sel_t SEL_RET  = 3'd4;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. push and pop together perform a swap of the
// top entry. A push while full overwrites the oldest entry; a pop while empty
// is ignored. ovf/unf are single-cycle pulses for the caller to make sticky.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       top,
  output logic [clog2(DEPTH):0]  count,
  output logic                   ovf,
  output logic                   unf
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic             empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Pointer, count and write-port decode for push / pop / swap.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    ovf     = 1'b0;
    unf     = 1'b0;
    if (push && pop) begin
      wr_en = 1'b1;
      if (empty) begin
        // Swap on an empty stack degenerates to a plain push.
        wr_idx  = ptr_q + PW'(1);
        ptr_d   = ptr_q + PW'(1);
        count_d = count_q + (PW + 1)'(1);
        unf     = 1'b1;
      end
    end else if (push) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q + PW'(1);
      ptr_d  = ptr_q + PW'(1);
      if (full) begin
        ovf = 1'b1;
      end else begin
        count_d = count_q + (PW + 1)'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf = 1'b1;
      end else begin
        ptr_d   = ptr_q - PW'(1);
        count_d = count_q - (PW + 1)'(1);
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_idx] <= wdata;
    end
  end

  assign top   = mem_q[ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pc_ras_unit.sv
// Program-counter unit with branch/jump redirect and call/return through an
// internal return-address stack. Define PC_PREV_EN to add the prevPC output,
// which captures the pre-update PC on every PCWrite edge.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH     = 16,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     INC       = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCWrite,
  input  logic                  br_taken,
  input  logic [WIDTH-1:0]      br_target,
  input  logic                  jump,
  input  logic [WIDTH-1:0]      jump_target,
  input  logic                  call,
  input  logic [WIDTH-1:0]      call_target,
  input  logic                  ret,
  output logic [WIDTH-1:0]      updatedPC,
  output logic [clog2(DEPTH):0] ras_count,
  output logic                  ras_empty,
  output logic                  ras_full,
  output logic                  ras_ovf,
  output logic                  ras_unf
`ifdef PC_PREV_EN
  ,
  output logic [WIDTH-1:0]      prevPC
`endif
);

  localparam int unsigned CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    cnt;
  logic             stk_empty;
  logic             ovf_pulse, unf_pulse;
  logic             ovf_q, unf_q;
  pc_sel_t          sel;

  assign seq_pc    = pc_q + WIDTH'(INC);
  assign stk_empty = (cnt == '0);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (PCWrite & call),
    .pop   (PCWrite & ret),
    .wdata (seq_pc),
    .top   (ras_top),
    .count (cnt),
    .ovf   (ovf_pulse),
    .unf   (unf_pulse)
  );

  // Priority select: ret > call > jump > branch > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (ret) begin
      if (!stk_empty) begin
        sel = SEL_RET;
      end else if (call) begin
        sel = SEL_CALL;
      end
    end else if (call) begin
      sel = SEL_CALL;
    end else if (jump) begin
      sel = SEL_JMP;
    end else if (br_taken) begin
      sel = SEL_BR;
    end
  end

  // Next-PC mux.
  always_comb begin
    pc_d = seq_pc;
    unique case (sel)
      SEL_RET:  pc_d = ras_top;
      SEL_CALL: pc_d = call_target;
      SEL_JMP:  pc_d = jump_target;
      SEL_BR:   pc_d = br_target;
      default:  pc_d = seq_pc;
    endcase
  end

  // PC register and sticky RAS error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (PCWrite) begin
        pc_q <= pc_d;
      end
      ovf_q <= ovf_q | ovf_pulse;
      unf_q <= unf_q | unf_pulse;
    end
  end

`ifdef PC_PREV_EN
  logic [WIDTH-1:0] prev_q;

  // Pre-update PC capture for trace/exception reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= RESET_VEC;
    end else if (PCWrite) begin
      prev_q <= pc_q;
    end
  end

  assign prevPC = prev_q;
`endif

  assign updatedPC = pc_q;
  assign ras_count = cnt;
  assign ras_empty = stk_empty;
  assign ras_full  = (cnt == CW'(DEPTH));
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed self-checking bench for pc_ras_unit (WIDTH=16, DEPTH=4, INC=1).
module tb_pc_ras_unit;

  logic        clk = 1'b0;
  logic        reset, PCWrite, br_taken, jump, call, ret;
  logic [15:0] br_target, jump_target, call_target;
  logic [15:0] updatedPC;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_PREV_EN
  logic [15:0] prevPC;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_ras_unit #(
    .WIDTH     (16),
    .DEPTH     (4),
    .INC       (1),
    .RESET_VEC (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .call        (call),
    .call_target (call_target),
    .ret         (ret),
    .updatedPC   (updatedPC),
    .ras_count   (ras_count),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
`ifdef PC_PREV_EN
    ,
    .prevPC      (prevPC)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  task automatic do_jump(input logic [15:0] tgt);
    idle_inputs(); jump = 1; jump_target = tgt; step(); jump = 0;
  endtask

  task automatic do_call(input logic [15:0] tgt);
    idle_inputs(); call = 1; call_target = tgt; step(); call = 0;
  endtask

  task automatic do_ret();
    idle_inputs(); ret = 1; step(); ret = 0;
  endtask

  logic [15:0] ret_exp [4];

  initial begin
    reset = 1; PCWrite = 0; idle_inputs();
    br_target = '0; jump_target = '0; call_target = '0;
    ret_exp[0] = 16'h0501; ret_exp[1] = 16'h0401;
    ret_exp[2] = 16'h0301; ret_exp[3] = 16'h0201;
    #2;
    step();
    reset = 0;
    check("rst_pc", updatedPC, 16'h0000);
    check("rst_cnt", ras_count, 3'd0);
    check("rst_empty", ras_empty, 1'b1);
    check("rst_full", ras_full, 1'b0);
    check("rst_ovf", ras_ovf, 1'b0);
    check("rst_unf", ras_unf, 1'b0);

    // Sequential increment.
    PCWrite = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("seq%0d", i), updatedPC, 32'(i));
    end
    check("seq_cnt", ras_count, 3'd0);
    check("seq_empty", ras_empty, 1'b1);

    // Stall holds PC even with jump asserted.
    PCWrite = 0; jump = 1; jump_target = 16'hAFAA;
    step();
    check("stall_pc", updatedPC, 16'h0003);

    // Jump beats branch.
    PCWrite = 1; br_taken = 1; br_target = 16'h1234;
    step();
    check("prio_jmp", updatedPC, 16'hAFAA);
    jump = 0;
    step();
    check("branch", updatedPC, 16'h1234);
    br_taken = 0;

    // Wrap at 2^16.
    do_jump(16'hFFFF);
    check("jmp_ffff", updatedPC, 16'hFFFF);
    step();
    check("wrap", updatedPC, 16'h0000);

    // Simple call / return.
    do_jump(16'h0010);
    do_call(16'h0200);
    check("call_pc", updatedPC, 16'h0200);
    check("call_cnt", ras_count, 3'd1);
    do_ret();
    check("ret_pc", updatedPC, 16'h0011);
    check("ret_cnt", ras_count, 3'd0);
    check("ret_ovf", ras_ovf, 1'b0);
    check("ret_unf", ras_unf, 1'b0);

    // Stalled call does not push.
    PCWrite = 0; call = 1; call_target = 16'h0777;
    step();
    call = 0; PCWrite = 1;
    check("stall_call_pc", updatedPC, 16'h0011);
    check("stall_call_cnt", ras_count, 3'd0);

    // Overflow: five calls from 0100..0500.
    do_jump(16'h0100);
    for (int i = 2; i <= 5; i++) do_call(16'(i * 256));
    check("four_cnt", ras_count, 3'd4);
    check("four_full", ras_full, 1'b1);
    check("four_ovf", ras_ovf, 1'b0);
    do_call(16'h0600);
    check("ovf_pc", updatedPC, 16'h0600);
    check("ovf_cnt", ras_count, 3'd4);
    check("ovf_flag", ras_ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      check($sformatf("pop%0d", i), updatedPC, ret_exp[i]);
    end
    check("pop_empty", ras_empty, 1'b1);
    do_ret();
    check("unf_pc", updatedPC, 16'h0202);
    check("unf_flag", ras_unf, 1'b1);
    check("unf_cnt", ras_count, 3'd0);

    // Coroutine swap: top=0011 at PC=0200.
    do_jump(16'h0010);
    do_call(16'h0200);
    idle_inputs(); call = 1; ret = 1; call_target = 16'h0999;
    step();
    idle_inputs();
    check("swap_pc", updatedPC, 16'h0011);
    check("swap_cnt", ras_count, 3'd1);
    do_ret();
    check("swap_top", updatedPC, 16'h0201);

    // Reset with call pending: reset wins.
    do_call(16'h0300);
    check("pre_rst_cnt", ras_count, 3'd1);
    reset = 1; call = 1; call_target = 16'h0555;
    step();
    reset = 0; call = 0;
    check("mrst_pc", updatedPC, 16'h0000);
    check("mrst_cnt", ras_count, 3'd0);
    check("mrst_ovf", ras_ovf, 1'b0);
    check("mrst_unf", ras_unf, 1'b0);

    // Swap on empty stack acts as a call and flags underflow.
    idle_inputs(); call = 1; ret = 1; call_target = 16'h0300;
    step();
    idle_inputs();
    check("eswap_pc", updatedPC, 16'h0300);
    check("eswap_cnt", ras_count, 3'd1);
    check("eswap_unf", ras_unf, 1'b1);
    do_ret();
    check("eswap_ret", updatedPC, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
